clk_gen: RTL and testbench

CLK_GEN -- requirements
Module: clk_gen

---
 rtl/clk_gen.sv | 88 ++++++++
 tb/tb_clk_gen.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/clk_gen.sv
// clk_gen: behavioural, simulation-only free-running clock source.
// Generates clk/clk_n after an active-low asynchronous reset releases, counts
// rising edges and flags lock after LOCK_CYCLES edges.
// Optional watchdog: define CLK_GEN_WATCHDOG_EN to end simulation at edge MAX_CYCLES.
`timescale 1ns/1ps

module clk_gen #(
    parameter int HALF_PERIOD = 1,
    parameter int START_DELAY = 0,
    parameter int CNT_W       = 32,
    parameter int LOCK_CYCLES = 4,
    parameter int MAX_CYCLES  = 1000
) (
    input  logic             rst,
    output logic             clk,
    output logic             clk_n,
    output logic [CNT_W-1:0] cycle_count,
    output logic             locked
);

    typedef enum logic [1:0] {IDLE, DELAY, RUN} state_t;

    if (HALF_PERIOD < 1 || LOCK_CYCLES < 1 || MAX_CYCLES < 0) begin : g_bad_params
        $error("clk_gen: illegal parameter values");
    end

`ifdef CLK_GEN_WATCHDOG_EN
    localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(MAX_CYCLES);
`endif

    // Declaration initialisers give defined reset values before any rst activity.
    state_t             state  = IDLE;
    logic               clk_r  = 1'b0;
    logic [CNT_W-1:0]   cnt    = '0;
    logic               lock_r = 1'b0;
    int unsigned        edges  = 0;
    int unsigned        epoch  = 0;

    assign clk         = clk_r;
    assign clk_n       = ~clk_r;
    assign cycle_count = cnt;
    assign locked      = lock_r;

    // One toggling thread per reset release; it retires itself as soon as the
    // epoch it was launched with is superseded, which cancels pending toggles.
    task automatic run_thread(input int unsigned my);
        #(START_DELAY + HALF_PERIOD);
        while (my == epoch) begin
            state = RUN;
            clk_r = 1'b1;
            cnt   = cnt + 1'b1;
            if (edges < LOCK_CYCLES)
                edges = edges + 1;
            if (edges >= LOCK_CYCLES)
                lock_r = 1'b1;
`ifdef CLK_GEN_WATCHDOG_EN
            if (MAX_CYCLES > 0 && cnt == WD_LIMIT) begin
                $display("clk_gen: watchdog timeout at cycle %0d, time %0t", cnt, $time);
                $finish;
            end
`endif
            #(HALF_PERIOD);
            if (my != epoch || state != RUN)
                break;
            clk_r = 1'b0;
            #(HALF_PERIOD);
        end
    endtask

    // Reset control: any rst change invalidates the running thread and applies
    // reset values at once; a release (including rst=1 at time 0) starts DELAY.
    always begin : ctrl
        epoch  = epoch + 1;
        clk_r  = 1'b0;
        cnt    = '0;
        lock_r = 1'b0;
        edges  = 0;
        state  = IDLE;
        if (rst === 1'b1) begin
            state = DELAY;
            fork
                run_thread(epoch);
            join_none
        end
        @(rst);
    end

endmodule

// File: tb/tb_clk_gen.sv
// Testbench for clk_gen: directed checks on a default-parameter instance, then
// randomized reset sequences on a second instance compared to a timing model.
`timescale 1ns/1ps

module tb_clk_gen;

    localparam int HP2 = 3;
    localparam int SD2 = 4;
    localparam int CW2 = 2;
    localparam int LK2 = 5;

    logic        rst1 = 1'b0;
    logic        clk1, clk1_n, locked1;
    logic [31:0] cnt1;

    logic           rst2 = 1'b0;
    logic           clk2, clk2_n, locked2;
    logic [CW2-1:0] cnt2;

    int total = 0;
    int bad   = 0;

    clk_gen dut (
        .rst         (rst1),
        .clk         (clk1),
        .clk_n       (clk1_n),
        .cycle_count (cnt1),
        .locked      (locked1)
    );

    clk_gen #(
        .HALF_PERIOD (HP2),
        .START_DELAY (SD2),
        .CNT_W       (CW2),
        .LOCK_CYCLES (LK2),
        .MAX_CYCLES  (0)
    ) dut2 (
        .rst         (rst2),
        .clk         (clk2),
        .clk_n       (clk2_n),
        .cycle_count (cnt2),
        .locked      (locked2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $realtime);
        end
    endtask

    // Reference timing: u time units after release (sampled mid-unit), how many
    // rising edges have happened and whether clk is in its high phase.
    function automatic void model(input int u, output int edges, output logic hi);
        int e;
        e = u - SD2 - HP2;
        if (e < 0) begin
            edges = 0;
            hi    = 1'b0;
        end else begin
            edges = e / (2 * HP2) + 1;
            hi    = (e % (2 * HP2)) < HP2;
        end
    endfunction

    initial begin
        int   low, high, k;
        logic eclk;

        // time-0 reset values
        #0.5;
        chk("t0_clk", {31'd0, clk1}, 32'd0);
        chk("t0_clk_n", {31'd0, clk1_n}, 32'd1);
        chk("t0_cnt", cnt1, 32'd0);
        chk("t0_locked", {31'd0, locked1}, 32'd0);
        chk("t0_clk2", {31'd0, clk2}, 32'd0);

        // release at 5 -> first rise at 6
        #4.5; rst1 = 1'b1;
        #0.5; chk("t5_clk", {31'd0, clk1}, 32'd0);
        #1;   chk("t6_clk", {31'd0, clk1}, 32'd1);
              chk("t6_clk_n", {31'd0, clk1_n}, 32'd0);
              chk("t6_cnt", cnt1, 32'd1);
        #1;   chk("t7_clk", {31'd0, clk1}, 32'd0);
        #1;   chk("t8_clk", {31'd0, clk1}, 32'd1);
              chk("t8_cnt", cnt1, 32'd2);
        #2;   chk("t10_cnt", cnt1, 32'd3);
              chk("t10_locked", {31'd0, locked1}, 32'd0);
        #2;   chk("t12_locked", {31'd0, locked1}, 32'd1);
              chk("t12_cnt", cnt1, 32'd4);

        // reset at 13, re-release at 20 -> rise at 21
        #0.5; rst1 = 1'b0;
        #0.1; chk("t13_clk", {31'd0, clk1}, 32'd0);
              chk("t13_cnt", cnt1, 32'd0);
              chk("t13_locked", {31'd0, locked1}, 32'd0);
              chk("t13_clk_n", {31'd0, clk1_n}, 32'd1);
        #6.9; rst1 = 1'b1;
        #0.5; chk("t20_clk", {31'd0, clk1}, 32'd0);
        #1;   chk("t21_clk", {31'd0, clk1}, 32'd1);
              chk("t21_cnt", cnt1, 32'd1);

        // reset mid-high phase drops clk immediately
        rst1 = 1'b0;
        #0.1; chk("midhigh_clk", {31'd0, clk1}, 32'd0);
              chk("midhigh_cnt", cnt1, 32'd0);

        // short glitch restarts the delay: release 22, rise 23, glitch 23.2-23.5
        #0.4; rst1 = 1'b1;
        #1.2; rst1 = 1'b0;
        #0.3; rst1 = 1'b1;
        #0.7; chk("glitch_clk_lo", {31'd0, clk1}, 32'd0);
        #0.5; chk("glitch_clk_hi", {31'd0, clk1}, 32'd1);
              chk("glitch_cnt", cnt1, 32'd1);
        #0.3; rst1 = 1'b0;

        // randomized reset/run sequences on the second instance
        for (int it = 0; it < 12; it++) begin
            rst2 = 1'b0;
            #0.5;
            chk("r_rst_clk", {31'd0, clk2}, 32'd0);
            chk("r_rst_clk_n", {31'd0, clk2_n}, 32'd1);
            chk("r_rst_cnt", {30'd0, cnt2}, 32'd0);
            chk("r_rst_locked", {31'd0, locked2}, 32'd0);
            low  = $urandom_range(1, 4);
            high = (it == 0) ? 40 : $urandom_range(3, 45);
            #(low - 0.5);
            rst2 = 1'b1;
            for (int u = 0; u < high; u++) begin
                #0.5;
                model(u, k, eclk);
                chk("r_clk", {31'd0, clk2}, {31'd0, eclk});
                chk("r_clk_n", {31'd0, clk2_n}, {31'd0, ~eclk});
                chk("r_cnt", {30'd0, cnt2}, 32'(k % (1 << CW2)));
                chk("r_locked", {31'd0, locked2}, {31'd0, k >= LK2});
                #0.5;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
